// File: rtl/vx_csr_io_bridge.sv
// -----------------------------------------------------------------------------
// vx_csr_io_bridge
//
// Host-side front end for the CSR IO port of the CSR arbitration stage. Takes
// one CSR read/write command from the host, issues it as a CSR IO request,
// waits for the matching response and returns the old CSR value to the host.
// Exactly one transaction is in flight at a time; host commands arriving while
// busy are simply not accepted (host_req_ready stays low).
//
// Optional feature (compile-time macro VX_CSR_IO_TIMEOUT_EN):
//   A watchdog counts cycles spent in REQ/WAIT. On reaching TIMEOUT_CYCLES-1
//   without a handshake the access is aborted and the host gets err=1,
//   data=0. If the abort happened after the request was accepted, the late
//   response is still owed by the CSR stage; drop_pending swallows it and
//   blocks new commands until it has arrived.
//   Without the macro there is no counter, no drop logic and host_rsp_err=0.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising clk edge where valid and ready are both 1. Once valid is raised
// it and its payload stay stable until the transfer (the watchdog abort of
// csr_io_req_valid is the single exception). Every output is a flop.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   host_req_*           host command channel (rw=1 write, addr, data)
//   host_rsp_*           host response channel (data = old CSR value, err)
//   csr_io_req_*         request to the CSR arbitration stage
//   csr_io_rsp_*         response from the CSR arbitration stage
//
// The FSM state register is named "state" (type state_t) so checkers can bind
// to it directly.
// -----------------------------------------------------------------------------
module vx_csr_io_bridge #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  host_req_valid,
  input  logic                  host_req_rw,
  input  logic [ADDR_WIDTH-1:0] host_req_addr,
  input  logic [DATA_WIDTH-1:0] host_req_data,
  output logic                  host_req_ready,

  output logic                  host_rsp_valid,
  output logic [DATA_WIDTH-1:0] host_rsp_data,
  output logic                  host_rsp_err,
  input  logic                  host_rsp_ready,

  output logic                  csr_io_req_valid,
  output logic                  csr_io_req_rw,
  output logic [ADDR_WIDTH-1:0] csr_io_req_addr,
  output logic [DATA_WIDTH-1:0] csr_io_req_data,
  input  logic                  csr_io_req_ready,

  input  logic                  csr_io_rsp_valid,
  input  logic [DATA_WIDTH-1:0] csr_io_rsp_data,
  output logic                  csr_io_rsp_ready
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("vx_csr_io_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_d;
  logic                  host_req_ready_d;
  logic                  host_rsp_valid_d;
  logic [DATA_WIDTH-1:0] host_rsp_data_d;
  logic                  csr_io_req_valid_d;
  logic                  csr_io_req_rw_d;
  logic [ADDR_WIDTH-1:0] csr_io_req_addr_d;
  logic [DATA_WIDTH-1:0] csr_io_req_data_d;
  logic                  csr_io_rsp_ready_d;

`ifdef VX_CSR_IO_TIMEOUT_EN
  localparam int              CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          drop_pending;
  logic          drop_pending_d;
  logic          host_rsp_err_d;
  logic          expire;
`else
  assign host_rsp_err = 1'b0;
`endif

  // Next-state and next-output logic. Every output register is computed here
  // and loaded in the single always_ff below.
  always_comb begin
    state_d            = state;
    host_rsp_valid_d   = host_rsp_valid;
    host_rsp_data_d    = host_rsp_data;
    csr_io_req_valid_d = csr_io_req_valid;
    csr_io_req_rw_d    = csr_io_req_rw;
    csr_io_req_addr_d  = csr_io_req_addr;
    csr_io_req_data_d  = csr_io_req_data;
    csr_io_rsp_ready_d = csr_io_rsp_ready;
`ifdef VX_CSR_IO_TIMEOUT_EN
    cnt_d              = cnt;
    drop_pending_d     = drop_pending;
    host_rsp_err_d     = host_rsp_err;
    expire             = (cnt == CNT_MAX);
`endif

    case (state)
      IDLE: begin
        if (host_req_valid && host_req_ready) begin
          csr_io_req_valid_d = 1'b1;
          csr_io_req_rw_d    = host_req_rw;
          csr_io_req_addr_d  = host_req_addr;
          csr_io_req_data_d  = host_req_data;
          state_d            = REQ;
`ifdef VX_CSR_IO_TIMEOUT_EN
          cnt_d              = '0;
`endif
        end
      end

      REQ: begin
`ifdef VX_CSR_IO_TIMEOUT_EN
        cnt_d = cnt + CW'(1);
`endif
        // A handshake in the expiry cycle takes priority over the abort.
        if (csr_io_req_ready) begin
          csr_io_req_valid_d = 1'b0;
          csr_io_rsp_ready_d = 1'b1;
          state_d            = WAIT;
        end
`ifdef VX_CSR_IO_TIMEOUT_EN
        else if (expire) begin
          // Request never accepted: nothing is owed, so no drop needed.
          csr_io_req_valid_d = 1'b0;
          host_rsp_valid_d   = 1'b1;
          host_rsp_data_d    = '0;
          host_rsp_err_d     = 1'b1;
          state_d            = RSP;
        end
`endif
      end

      WAIT: begin
`ifdef VX_CSR_IO_TIMEOUT_EN
        cnt_d = cnt + CW'(1);
`endif
        if (csr_io_rsp_valid) begin
          host_rsp_valid_d   = 1'b1;
          host_rsp_data_d    = csr_io_rsp_data;
          csr_io_rsp_ready_d = 1'b0;
          state_d            = RSP;
`ifdef VX_CSR_IO_TIMEOUT_EN
          host_rsp_err_d     = 1'b0;
`endif
        end
`ifdef VX_CSR_IO_TIMEOUT_EN
        else if (expire) begin
          // The stage accepted the request and still owes a response; keep
          // csr_io_rsp_ready high so it can be swallowed later.
          host_rsp_valid_d = 1'b1;
          host_rsp_data_d  = '0;
          host_rsp_err_d   = 1'b1;
          drop_pending_d   = 1'b1;
          state_d          = RSP;
        end
`endif
      end

      RSP: begin
        if (host_rsp_ready) begin
          host_rsp_valid_d = 1'b0;
          state_d          = IDLE;
`ifdef VX_CSR_IO_TIMEOUT_EN
          host_rsp_err_d   = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase

`ifdef VX_CSR_IO_TIMEOUT_EN
    // The late response of an aborted access may arrive in RSP or IDLE.
    if (drop_pending && csr_io_rsp_valid && csr_io_rsp_ready) begin
      drop_pending_d     = 1'b0;
      csr_io_rsp_ready_d = 1'b0;
    end
    host_req_ready_d = (state_d == IDLE) && !drop_pending_d;
`else
    host_req_ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      host_req_ready   <= 1'b0;
      host_rsp_valid   <= 1'b0;
      host_rsp_data    <= '0;
      csr_io_req_valid <= 1'b0;
      csr_io_req_rw    <= 1'b0;
      csr_io_req_addr  <= '0;
      csr_io_req_data  <= '0;
      csr_io_rsp_ready <= 1'b0;
`ifdef VX_CSR_IO_TIMEOUT_EN
      cnt              <= '0;
      drop_pending     <= 1'b0;
      host_rsp_err     <= 1'b0;
`endif
    end else begin
      state            <= state_d;
      host_req_ready   <= host_req_ready_d;
      host_rsp_valid   <= host_rsp_valid_d;
      host_rsp_data    <= host_rsp_data_d;
      csr_io_req_valid <= csr_io_req_valid_d;
      csr_io_req_rw    <= csr_io_req_rw_d;
      csr_io_req_addr  <= csr_io_req_addr_d;
      csr_io_req_data  <= csr_io_req_data_d;
      csr_io_rsp_ready <= csr_io_rsp_ready_d;
`ifdef VX_CSR_IO_TIMEOUT_EN
      cnt              <= cnt_d;
      drop_pending     <= drop_pending_d;
      host_rsp_err     <= host_rsp_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_vx_csr_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_vx_csr_io_bridge
//
// Testbench for vx_csr_io_bridge. Inputs change and outputs are sampled on
// the falling clock edge. The CSR arbitration stage is emulated by a small
// register file (stage_mem) that returns the old value and applies writes.
// Expected host responses come from a table (directed vectors) or from an
// independent reference register file (ref_mem, random phase).
// -----------------------------------------------------------------------------
module tb_vx_csr_io_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          host_req_valid;
  logic          host_req_rw;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_data;
  logic          host_req_ready;
  logic          host_rsp_valid;
  logic [DW-1:0] host_rsp_data;
  logic          host_rsp_err;
  logic          host_rsp_ready;
  logic          csr_io_req_valid;
  logic          csr_io_req_rw;
  logic [AW-1:0] csr_io_req_addr;
  logic [DW-1:0] csr_io_req_data;
  logic          csr_io_req_ready;
  logic          csr_io_rsp_valid;
  logic [DW-1:0] csr_io_rsp_data;
  logic          csr_io_rsp_ready;

  vx_csr_io_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .host_req_valid   (host_req_valid),
    .host_req_rw      (host_req_rw),
    .host_req_addr    (host_req_addr),
    .host_req_data    (host_req_data),
    .host_req_ready   (host_req_ready),
    .host_rsp_valid   (host_rsp_valid),
    .host_rsp_data    (host_rsp_data),
    .host_rsp_err     (host_rsp_err),
    .host_rsp_ready   (host_rsp_ready),
    .csr_io_req_valid (csr_io_req_valid),
    .csr_io_req_rw    (csr_io_req_rw),
    .csr_io_req_addr  (csr_io_req_addr),
    .csr_io_req_data  (csr_io_req_data),
    .csr_io_req_ready (csr_io_req_ready),
    .csr_io_rsp_valid (csr_io_rsp_valid),
    .csr_io_rsp_data  (csr_io_rsp_data),
    .csr_io_rsp_ready (csr_io_rsp_ready)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]   exp_q[$];
  logic [AW+DW:0]  req_q[$];
  logic [DW-1:0]   stage_mem [logic [AW-1:0]];
  logic [DW-1:0]   ref_mem   [logic [AW-1:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic wait_ready();
    int k;
    k = 0;
    while (host_req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("host_req_ready_wait", host_req_ready, 1);
  endtask

  // Presents one command; returns in the cycle right after the accept edge.
  task automatic accept_cmd(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wait_ready();
    host_req_valid = 1'b1;
    host_req_rw    = rw;
    host_req_addr  = addr;
    host_req_data  = data;
    @(negedge clk);
    // Scramble the command bus: the bridge must have latched its copy.
    host_req_valid = 1'b0;
    host_req_rw    = 1'($urandom);
    host_req_addr  = AW'($urandom);
    host_req_data  = $urandom;
  endtask

  // Emulated CSR stage: returns the old value, applies writes.
  task automatic stage_access(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              output logic [DW-1:0] old);
    old = stage_mem.exists(addr) ? stage_mem[addr] : '0;
    if (rw) stage_mem[addr] = data;
  endtask

  task automatic do_txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int req_stall, input int rsp_delay, input int host_stall,
                        input bit early, input logic [DW-1:0] exp_data);
    logic [AW+DW:0] exp_req;
    logic [DW-1:0]  exp_rsp;
    logic [DW-1:0]  old;
    exp_q.push_back(exp_data);
    req_q.push_back({rw, addr, data});
    accept_cmd(rw, addr, data);
    exp_req = req_q.pop_front();
    check("req_ready_low_after_accept", host_req_ready, 0);
    check("req_valid", csr_io_req_valid, 1);
    check("req_fields", {csr_io_req_rw, csr_io_req_addr, csr_io_req_data}, exp_req);
    for (int i = 0; i < req_stall; i++) begin
      check("rsp_ready_in_req", csr_io_rsp_ready, 0);
      if (early && i == 0) begin
        csr_io_rsp_valid = 1'b1;
        csr_io_rsp_data  = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      csr_io_rsp_valid = 1'b0;
      check("req_hold", {host_rsp_valid, csr_io_req_valid, csr_io_req_rw, csr_io_req_addr, csr_io_req_data},
            {1'b0, 1'b1, exp_req});
    end
    stage_access(csr_io_req_rw, csr_io_req_addr, csr_io_req_data, old);
    csr_io_req_ready = 1'b1;
    @(negedge clk);
    csr_io_req_ready = 1'b0;
    check("req_valid_cleared", csr_io_req_valid, 0);
    check("rsp_ready_in_wait", csr_io_rsp_ready, 1);
    repeat (rsp_delay) @(negedge clk);
    check("no_host_rsp_before_csr_rsp", host_rsp_valid, 0);
    csr_io_rsp_valid = 1'b1;
    csr_io_rsp_data  = old;
    @(negedge clk);
    csr_io_rsp_valid = 1'b0;
    csr_io_rsp_data  = $urandom;
    exp_rsp = exp_q.pop_front();
    check("host_rsp_valid", host_rsp_valid, 1);
    check("rsp_ready_dropped", csr_io_rsp_ready, 0);
    check("host_rsp_data", host_rsp_data, exp_rsp);
    check("host_rsp_err", host_rsp_err, 0);
    for (int i = 0; i < host_stall; i++) begin
      host_req_valid = 1'b1;
      @(negedge clk);
      check("host_rsp_hold", {host_rsp_valid, host_rsp_data, host_rsp_err, host_req_ready},
            {1'b1, exp_rsp, 1'b0, 1'b0});
    end
    host_req_valid = 1'b0;
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    check("host_rsp_cleared", host_rsp_valid, 0);
    check("host_req_ready_back", host_req_ready, 1);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            req_stall;
    int            rsp_delay;
    int            host_stall;
    bit            early;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          rw;
    logic [DW-1:0] e;

    reset            = 1'b1;
    host_req_valid   = 1'b0;
    host_req_rw      = 1'b0;
    host_req_addr    = '0;
    host_req_data    = '0;
    host_rsp_ready   = 1'b0;
    csr_io_req_ready = 1'b0;
    csr_io_rsp_valid = 1'b0;
    csr_io_rsp_data  = '0;

    stage_mem[12'hC00] = 32'h0000_1234;
    stage_mem[12'h300] = 32'h0000_0008;
    stage_mem[12'hFFF] = 32'hFFFF_FFFF;

    //            rw    addr     data          rq rs hs early exp
    vecs[0] = '{1'b0, 12'hC00, 32'h0,          0, 3, 0, 1'b0, 32'h0000_1234};
    vecs[1] = '{1'b1, 12'h300, 32'hA5A5_A5A5,  5, 0, 0, 1'b0, 32'h0000_0008};
    vecs[2] = '{1'b0, 12'h300, 32'h0,          0, 0, 10, 1'b0, 32'hA5A5_A5A5};
    vecs[3] = '{1'b1, 12'h300, 32'h0,          0, 0, 0, 1'b0, 32'hA5A5_A5A5};
    vecs[4] = '{1'b0, 12'hFFF, 32'h0,          2, 1, 0, 1'b1, 32'hFFFF_FFFF};
    vecs[5] = '{1'b0, 12'h300, 32'h0,          0, 0, 0, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b0, 12'hC00, 32'h0,          1, 1, 3, 1'b0, 32'h0000_1234};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ctrl", {host_req_ready, host_rsp_valid, host_rsp_err, csr_io_req_valid, csr_io_req_rw, csr_io_rsp_ready}, 0);
    check("reset_rsp_data", host_rsp_data, 0);
    check("reset_req_fields", {csr_io_req_addr, csr_io_req_data}, 0);
    reset = 1'b0;
    check("ready_before_first_edge", host_req_ready, 0);
    @(negedge clk);
    check("ready_after_first_edge", host_req_ready, 1);

    // Directed table
    for (int i = 0; i < 7; i++)
      do_txn(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].req_stall,
             vecs[i].rsp_delay, vecs[i].host_stall, vecs[i].early, vecs[i].exp_data);

    // Randomized traffic on an address window untouched by the table
    for (int i = 0; i < 25; i++) begin
      a  = 12'h100 + AW'($urandom_range(0, 15));
      d  = $urandom;
      rw = 1'($urandom_range(0, 1));
      e  = ref_mem.exists(a) ? ref_mem[a] : '0;
      if (rw) ref_mem[a] = d;
      do_txn(rw, a, d, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0, e);
    end

    // Reset in the middle of WAIT
    accept_cmd(1'b1, 12'h055, 32'h1111_2222);
    csr_io_req_ready = 1'b1;
    @(negedge clk);
    csr_io_req_ready = 1'b0;
    check("mid_wait_rsp_ready", csr_io_rsp_ready, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ctrl", {host_req_ready, host_rsp_valid, host_rsp_err, csr_io_req_valid, csr_io_req_rw, csr_io_rsp_ready}, 0);
    check("async_reset_req_fields", {csr_io_req_addr, csr_io_req_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    check("ready_low_until_edge", host_req_ready, 0);
    @(negedge clk);
    check("ready_after_reset_release", {host_req_ready, host_rsp_valid, csr_io_req_valid, csr_io_rsp_ready}, 4'b1000);
    do_txn(1'b0, 12'hC00, 32'h0, 0, 2, 1, 1'b0, 32'h0000_1234);

`ifdef VX_CSR_IO_TIMEOUT_EN
    // Timeout while the request is never accepted
    accept_cmd(1'b0, 12'h020, 32'h0);
    repeat (TO - 1) @(negedge clk);
    check("req_to_not_yet", {host_rsp_valid, csr_io_req_valid}, 2'b01);
    @(negedge clk);
    check("req_to_rsp", {host_rsp_valid, host_rsp_err, csr_io_req_valid, csr_io_rsp_ready}, 4'b1100);
    check("req_to_data", host_rsp_data, 0);
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    check("req_to_ready_back", host_req_ready, 1);

    // Timeout in WAIT, then the late response is swallowed
    accept_cmd(1'b0, 12'h021, 32'h0);
    csr_io_req_ready = 1'b1;
    @(negedge clk);
    csr_io_req_ready = 1'b0;
    repeat (TO - 2) @(negedge clk);
    check("wait_to_not_yet", host_rsp_valid, 0);
    @(negedge clk);
    check("wait_to_rsp", {host_rsp_valid, host_rsp_err, csr_io_rsp_ready}, 3'b111);
    check("wait_to_data", host_rsp_data, 0);
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    repeat (3) begin
      host_req_valid = 1'b1;
      @(negedge clk);
      check("drop_blocks_ready", {host_req_ready, csr_io_rsp_ready, csr_io_req_valid}, 3'b010);
    end
    host_req_valid   = 1'b0;
    csr_io_rsp_valid = 1'b1;
    csr_io_rsp_data  = 32'h0000_DEAD;
    @(negedge clk);
    csr_io_rsp_valid = 1'b0;
    check("drop_done", {host_req_ready, csr_io_rsp_ready, host_rsp_valid}, 3'b100);
    check("drop_not_forwarded", host_rsp_data, 0);

    // Response exactly in the expiry cycle wins
    accept_cmd(1'b0, 12'h022, 32'h0);
    csr_io_req_ready = 1'b1;
    @(negedge clk);
    csr_io_req_ready = 1'b0;
    repeat (TO - 2) @(negedge clk);
    csr_io_rsp_valid = 1'b1;
    csr_io_rsp_data  = 32'h0000_BEEF;
    @(negedge clk);
    csr_io_rsp_valid = 1'b0;
    check("race_rsp", {host_rsp_valid, host_rsp_err, csr_io_rsp_ready}, 3'b100);
    check("race_data", host_rsp_data, 32'h0000_BEEF);
    host_rsp_ready = 1'b1;
    @(negedge clk);
    host_rsp_ready = 1'b0;
    check("race_no_drop", {host_req_ready, csr_io_rsp_ready}, 2'b10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
